// File: rtl/wb_write_queue_if.sv
// Writeback queue bus: datapath request handshake, register-bank
// write port, and the two hazard query/response pairs.
interface wb_write_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          in_valid;
  logic          in_ready;
  logic [5:0]    in_reg;
  logic [31:0]   in_data;
  logic          wb_stall;
  logic          reg_write;
  logic [5:0]    reg_escrita;
  logic [31:0]   escreve_dado;
  logic [5:0]    q_reg1;
  logic [5:0]    q_reg2;
  logic          hazard1;
  logic          hazard2;
  logic [CW-1:0] count;

  modport master (
    output in_valid, in_reg, in_data, wb_stall,
    output q_reg1, q_reg2,
    input  in_ready, reg_write, reg_escrita,
    input  escreve_dado, hazard1, hazard2, count
  );

  modport slave (
    input  in_valid, in_reg, in_data, wb_stall,
    input  q_reg1, q_reg2,
    output in_ready, reg_write, reg_escrita,
    output escreve_dado, hazard1, hazard2, count
  );
endinterface

// File: rtl/wb_write_queue.sv
// In-order writeback queue feeding the 64x32 register bank, with RAW hazard report.
// Define WB_BYPASS_EN to let a push into an empty, unstalled queue issue at once.
module wb_write_queue #(
  parameter int DEPTH   = 4,
  parameter bit DROP_R0 = 1'b1
) (
  input logic             clock,
  input logic             reset,
  wb_write_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [5:0]    mem_reg_q [DEPTH];
  logic [31:0]   mem_dat_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          we_q, we_d;
  logic [5:0]    idx_q, idx_d;
  logic [31:0]   dat_q, dat_d;

  logic full, empty, push, drop, enq;
  logic pop, byp, wr;
  logic h1, h2;

  always_comb begin
    full  = (count_q == CW'(DEPTH));
    empty = (count_q == '0);
    push  = bus.in_valid && !full;
    drop  = DROP_R0 && (bus.in_reg == 6'd0);
    enq   = push && !drop;
    pop   = !bus.wb_stall && !empty;
`ifdef WB_BYPASS_EN
    byp   = enq && empty && !bus.wb_stall;
`else
    byp   = 1'b0;
`endif
    wr    = enq && !byp;
  end

  always_comb begin
    we_d     = 1'b0;
    idx_d    = idx_q;
    dat_d    = dat_q;
    rd_ptr_d = rd_ptr_q + AW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(wr);
    count_d  = count_q + CW'(wr) - CW'(pop);
    if (pop) begin
      we_d  = 1'b1;
      idx_d = mem_reg_q[rd_ptr_q];
      dat_d = mem_dat_q[rd_ptr_q];
    end else if (byp) begin
      we_d  = 1'b1;
      idx_d = bus.in_reg;
      dat_d = bus.in_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      idx_q    <= '0;
      dat_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      idx_q    <= idx_d;
      dat_q    <= dat_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clock) begin
    if (!reset && wr) begin
      mem_reg_q[wr_ptr_q] <= bus.in_reg;
      mem_dat_q[wr_ptr_q] <= bus.in_data;
    end
  end

  // An entry is live when its distance from the head is below count.
  always_comb begin
    logic [AW-1:0] off;
    h1  = bus.reg_write && (bus.reg_escrita == bus.q_reg1);
    h2  = bus.reg_write && (bus.reg_escrita == bus.q_reg2);
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_ptr_q;
      if ({1'b0, off} < count_q) begin
        if (mem_reg_q[i] == bus.q_reg1) h1 = 1'b1;
        if (mem_reg_q[i] == bus.q_reg2) h2 = 1'b1;
      end
    end
    if (DROP_R0 && bus.q_reg1 == 6'd0) h1 = 1'b0;
    if (DROP_R0 && bus.q_reg2 == 6'd0) h2 = 1'b0;
  end

  assign bus.in_ready     = !full;
  assign bus.reg_write    = we_q;
  assign bus.reg_escrita  = idx_q;
  assign bus.escreve_dado = dat_q;
  assign bus.count        = count_q;
  assign bus.hazard1      = h1;
  assign bus.hazard2      = h2;
endmodule

// File: tb/tb_wb_write_queue.sv
// Directed plus randomized bench for wb_write_queue against a queue-level
// reference model of pending writes and the registered write port.
module tb_wb_write_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  wb_write_queue_if #(.DEPTH(DEPTH)) bus ();

  wb_write_queue #(.DEPTH(DEPTH), .DROP_R0(1'b1)) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [37:0] mq[$];
  logic        m_we;
  logic [5:0]  m_idx;
  logic [31:0] m_dat;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic hz(logic [5:0] q);
    if (q == 6'd0) return 1'b0;
    foreach (mq[i]) if (mq[i][37:32] == q) return 1'b1;
    return m_we && (m_idx == q);
  endfunction

  task automatic model_update();
    int          n;
    logic        enq;
    logic        byp;
    logic [37:0] e;
    n   = mq.size();
    byp = 1'b0;
    enq = bus.in_valid && (n < DEPTH) && (bus.in_reg != 6'd0);
    if (rst) begin
      mq.delete();
      m_we  = 1'b0;
      m_idx = '0;
      m_dat = '0;
    end else begin
      if (!bus.wb_stall && n > 0) begin
        e     = mq.pop_front();
        m_we  = 1'b1;
        m_idx = e[37:32];
        m_dat = e[31:0];
      end else begin
        m_we = 1'b0;
`ifdef WB_BYPASS_EN
        if (enq && n == 0 && !bus.wb_stall) begin
          m_we  = 1'b1;
          m_idx = bus.in_reg;
          m_dat = bus.in_data;
          byp   = 1'b1;
        end
`endif
      end
      if (enq && !byp) mq.push_back({bus.in_reg, bus.in_data});
    end
  endtask

  task automatic check_all();
    chk("reg_write", 32'(bus.reg_write), 32'(m_we));
    chk("reg_escrita", 32'(bus.reg_escrita), 32'(m_idx));
    chk("escreve_dado", bus.escreve_dado, m_dat);
    chk("count", 32'(bus.count), 32'(mq.size()));
    chk("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
    chk("hazard1", 32'(bus.hazard1), 32'(hz(bus.q_reg1)));
    chk("hazard2", 32'(bus.hazard2), 32'(hz(bus.q_reg2)));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic drive(logic v, logic [5:0] r, logic [31:0] d);
    bus.in_valid = v;
    bus.in_reg   = r;
    bus.in_data  = d;
  endtask

  initial begin
    m_we  = 1'b0;
    m_idx = '0;
    m_dat = '0;
    rst = 1'b1;
    bus.wb_stall = 1'b0;
    bus.q_reg1 = 6'd0;
    bus.q_reg2 = 6'd0;
    drive(1'b1, 6'd9, 32'h1234_5678);

    // reset with a request pending
    step();
    step();
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_we", 32'(bus.reg_write), 32'd0);
    rst = 1'b0;
    drive(1'b0, 6'd0, 32'd0);
    step();
    chk("rel_ready", 32'(bus.in_ready), 32'd1);

    // single write latency
    drive(1'b1, 6'd5, 32'hDEAD_BEEF);
    step();
    drive(1'b0, 6'd0, 32'd0);
    step();
    chk("t2_idx", 32'(bus.reg_escrita), 32'd5);
    chk("t2_dat", bus.escreve_dado, 32'hDEAD_BEEF);
    step();

    // stall fills the queue, then drains in order
    bus.wb_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 6'(i), 32'(i * 'h11));
      step();
    end
    drive(1'b1, 6'd5, 32'h55);
    step();
    chk("t3_count", 32'(bus.count), 32'd4);
    chk("t3_ready", 32'(bus.in_ready), 32'd0);
    bus.wb_stall = 1'b0;
    step();
    chk("t3_first", 32'(bus.reg_escrita), 32'd1);
    step();
    drive(1'b0, 6'd0, 32'd0);
    for (int i = 0; i < 6; i++) step();

    // hazard on a queued write
    bus.wb_stall = 1'b1;
    bus.q_reg1 = 6'd7;
    bus.q_reg2 = 6'd8;
    drive(1'b1, 6'd7, 32'h77);
    step();
    drive(1'b0, 6'd0, 32'd0);
    step();
    chk("t4_h1", 32'(bus.hazard1), 32'd1);
    chk("t4_h2", 32'(bus.hazard2), 32'd0);
    bus.wb_stall = 1'b0;
    step();
    step();
    step();
    chk("t4_h1_clr", 32'(bus.hazard1), 32'd0);

    // writes to reg 0 are swallowed
    bus.q_reg1 = 6'd0;
    drive(1'b1, 6'd0, 32'hFFFF_FFFF);
    step();
    drive(1'b0, 6'd0, 32'd0);
    chk("t5_count", 32'(bus.count), 32'd0);
    step();
    chk("t5_we", 32'(bus.reg_write), 32'd0);
    step();

    // reset in the middle of a drain
    bus.wb_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 6'(10 + i), 32'(32'hA0 + i));
      step();
    end
    drive(1'b0, 6'd0, 32'd0);
    bus.wb_stall = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_count", 32'(bus.count), 32'd0);
    chk("t6_we", 32'(bus.reg_write), 32'd0);
    for (int i = 0; i < 4; i++) step();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst          = ($urandom_range(0, 99) == 0);
      bus.wb_stall = ($urandom_range(0, 9) < 4);
      bus.q_reg1   = 6'($urandom_range(0, 12));
      bus.q_reg2   = 6'($urandom_range(0, 12));
      drive($urandom_range(0, 9) < 7,
            6'($urandom_range(0, 12)),
            $urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
